// File: rtl/netlist_pkg.sv
// Shared types and constants for the 3-input/2-output netlist exerciser.
package netlist_pkg;

  localparam int unsigned NUM_VEC       = 8;
  localparam logic [15:0] DEF_EXP_TABLE = 16'h8404;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Extract the {P,Q} pair for vector idx from a packed response table.
  function automatic logic [1:0] table_pair(input logic [15:0] tbl, input logic [2:0] idx);
    return tbl[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter with a registered zero flag; holds at zero.
module settle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Load takes priority over counting; the zero flag tracks the next count value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
      zero  <= 1'b1;
    end else if (load) begin
      cnt_r <= load_val;
      zero  <= (load_val == {W{1'b0}});
    end else if (en && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
      zero  <= (cnt_r == {{(W-1){1'b0}}, 1'b1});
    end else begin
      cnt_r <= cnt_r;
      zero  <= zero;
    end
  end

endmodule

// File: rtl/netlist_exerciser.sv
// Sweeps all 8 input vectors through an external 3-in/2-out netlist and
// compares each settled response against an expected table.
module netlist_exerciser
  import netlist_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [15:0] EXP_TABLE  = DEF_EXP_TABLE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        drv_a,
  output logic        drv_b,
  output logic        drv_c,
  input  logic        dut_p,
  input  logic        dut_q,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  err_count,
  output logic        first_fail_valid,
  output logic [2:0]  first_fail_idx,
  output logic [15:0] resp_log
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC - 1);
  localparam logic [2:0] LAST_IDX    = 3'(NUM_VEC - 1);

  state_t      state_r;
  logic [2:0]  idx_r;
  logic        timer_load_s;
  logic        timer_en_s;
  logic        timer_zero_s;
  logic [1:0]  sample_s;
  logic        mismatch_s;
  logic [3:0]  err_next_s;
  logic        active_s;

  settle_timer #(.W(4)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_s),
    .load_val (SETTLE_INIT),
    .en       (timer_en_s),
    .zero     (timer_zero_s)
  );

  // Timer control and per-sample compare decode.
  always_comb begin
    timer_load_s = 1'b0;
    timer_en_s   = 1'b0;
    active_s     = 1'b0;
    case (state_r)
      DRIVE:   begin timer_load_s = 1'b1; active_s = 1'b1; end
      SETTLE:  begin timer_en_s   = 1'b1; active_s = 1'b1; end
      SAMPLE:  active_s = 1'b1;
      default: active_s = 1'b0;
    endcase
    sample_s   = {dut_p, dut_q};
    mismatch_s = (sample_s != table_pair(EXP_TABLE, idx_r));
    if (mismatch_s) begin
      err_next_s = err_count + 4'd1;
    end else begin
      err_next_s = err_count;
    end
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      idx_r            <= 3'd0;
      {drv_a, drv_b, drv_c} <= 3'b000;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= 4'd0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= 3'd0;
      resp_log         <= 16'h0000;
    end else begin
      done <= 1'b0;
      if (active_s && abort) begin
        // Aborting discards any sample due this cycle.
        state_r <= DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
        pass    <= 1'b0;
      end else begin
        case (state_r)
          IDLE, DONE: begin
            if (start) begin
              state_r          <= DRIVE;
              busy             <= 1'b1;
              idx_r            <= 3'd0;
              pass             <= 1'b0;
              err_count        <= 4'd0;
              first_fail_valid <= 1'b0;
              first_fail_idx   <= 3'd0;
              resp_log         <= 16'h0000;
            end else begin
              state_r <= IDLE;
            end
          end
          DRIVE: begin
            {drv_a, drv_b, drv_c} <= idx_r;
            state_r <= SETTLE;
          end
          SETTLE: begin
            if (timer_zero_s) begin
              state_r <= SAMPLE;
            end else begin
              state_r <= SETTLE;
            end
          end
          SAMPLE: begin
            resp_log[{idx_r, 1'b0} +: 2] <= sample_s;
            err_count <= err_next_s;
            if (mismatch_s && !first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= idx_r;
            end
            if (idx_r == LAST_IDX) begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_next_s == 4'd0);
            end else begin
              idx_r   <= idx_r + 3'd1;
              state_r <= DRIVE;
            end
          end
          default: begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/netlist_exerciser.md
NETLIST_EXERCISER -- requirements
Module: netlist_exerciser

Interface
REQ-001 Parameter SETTLE_CYC, default 2, meaning clock cycles vectors are held before sampling (legal 1..15).
REQ-002 Parameter EXP_TABLE, default 16'h8404, meaning expected response table: bits [2i+1:2i] = {P,Q} for vector i = {A,B,C}, with A as MSB.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle pulse that begins a sweep; honoured only in IDLE or DONE.
REQ-006 abort  input  1  terminates an active sweep.
REQ-007 drv_a, drv_b, drv_c  output  1 each  stimulus driven to the 3-input/2-output combinational netlist under test.
REQ-008 dut_p, dut_q  input  1 each  responses from the netlist under test.
REQ-009 busy  output  1  high while a sweep is active.
REQ-010 done  output  1  one-cycle pulse when a sweep completes or aborts.
REQ-011 pass  output  1  high after a completed sweep with zero mismatches; held until the next start.
REQ-012 err_count  output  4  number of mismatching vectors in the last sweep (0..8).
REQ-013 first_fail_valid / first_fail_idx  output  1 / 3  flag and index of the lowest-index mismatching vector.
REQ-014 resp_log  output  16  captured {P,Q} per vector, same layout as EXP_TABLE.

Function
REQ-015 The FSM SHALL have states IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-016 IDLE: on start go to DRIVE; clear vector index to 0, err_count, first_fail_valid, pass and resp_log.
REQ-017 DRIVE: register {drv_a,drv_b,drv_c} = index; load settle counter with SETTLE_CYC-1; go to SETTLE.
REQ-018 SETTLE: decrement the counter each cycle; at zero go to SAMPLE; drive outputs hold steady.
REQ-019 SAMPLE: capture {dut_p,dut_q} into resp_log[2i+1:2i] and compare with EXP_TABLE[2i+1:2i].
REQ-020 On mismatch in SAMPLE: increment err_count; if first_fail_valid is 0, set it and load first_fail_idx = i.
REQ-021 SAMPLE with i<7: increment index and go to DRIVE; with i=7 go to DONE; the index SHALL NOT wrap past 7.
REQ-022 DONE: pulse done for one cycle; set pass = (err_count==0), using the count that includes the final sample; return to IDLE the next cycle.
REQ-023 Per-vector latency SHALL be SETTLE_CYC+2 cycles; a full sweep SHALL take 8*(SETTLE_CYC+2) cycles from start to the done pulse.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort in DRIVE/SETTLE/SAMPLE: go to DONE with pass forced to 0; a sample in the same cycle as abort is discarded.
REQ-026 start and abort in the same cycle in IDLE: start wins.
REQ-027 busy = 1 in DRIVE, SETTLE and SAMPLE; 0 in IDLE and DONE.
REQ-028 err_count is 4 bits wide and SHALL reach 8 without overflow.

Reset
REQ-029 When rst_n is low the block SHALL asynchronously enter IDLE with all outputs 0, including drv_*, resp_log, err_count, first_fail_idx, pass and done.
REQ-030 Reset mid-sweep SHALL discard the sweep; no done pulse is generated.

Structure
REQ-031 The state enum, vector count (8) and the default EXP_TABLE constant SHALL reside in the shared package netlist_pkg.
REQ-032 The settle timer SHALL be a separate sub-module, settle_timer (load, count-down, zero flag); all else stays in one module.

Verification
REQ-033 Golden DUT model (P = A&B&C, Q = ~B&C), SETTLE_CYC=2, start -> done at cycle 32, pass=1, err_count=0, resp_log=16'h8404.
REQ-034 DUT with Q stuck-at-0 -> err_count=2, first_fail_idx=1, pass=0, resp_log=16'h8000.
REQ-035 Golden DUT, abort in SETTLE of vector 3 -> done pulse, pass=0, busy=0, resp_log bits [15:6]=0.
REQ-036 Second start pulse at cycle 10 of a sweep -> ignored; done still at cycle 32.
REQ-037 rst_n low during vector 5 -> all outputs 0 immediately, no done pulse; a fresh start then sweeps normally and ends with pass=1.
REQ-038 SETTLE_CYC=1 with all-ones DUT outputs -> sweep ends at cycle 24, err_count=8, first_fail_idx=0.
